// File: rtl/console_pkg.sv
// Shared types and constants for the console game-select controller.
// Per-game vectors use bit 0 for pong and bit 1 for squash.
package console_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT_VS,
    BLANK
  } state_e;

  localparam logic GAME_PONG   = 1'b0;
  localparam logic GAME_SQUASH = 1'b1;

  localparam int GAME_BIT_PONG   = 0;
  localparam int GAME_BIT_SQUASH = 1;

  typedef logic [1:0] game_vec_t;

  typedef struct packed {
    logic      sel;
    game_vec_t game_en;
    game_vec_t game_rst_n;
    logic      blank_force;
    logic      busy;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_OUT_RESET = '{
    sel:         GAME_PONG,
    game_en:     2'b01,
    game_rst_n:  2'b11,
    blank_force: 1'b0,
    busy:        1'b0
  };

  function automatic game_vec_t game_onehot(input logic game);
    game_vec_t v;
    v = '0;
    if (game == GAME_SQUASH) v[GAME_BIT_SQUASH] = 1'b1;
    else                     v[GAME_BIT_PONG]   = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/game_select_ctrl_if.sv
// Board-side signals of the game-select controller: raw inputs and the
// select/enable/reset/blank controls driven towards the two games.
interface game_select_ctrl_if;
  import console_pkg::*;

  logic      mode_sw;
  logic      vga_vs;
  logic      sel;
  game_vec_t game_en;
  game_vec_t game_rst_n;
  logic      blank_force;
  logic      busy;

  modport slave (
    input  mode_sw, vga_vs,
    output sel, game_en, game_rst_n, blank_force, busy
  );

  modport master (
    output mode_sw, vga_vs,
    input  sel, game_en, game_rst_n, blank_force, busy
  );

endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stability counter for the raw mode switch.
// stable_o follows the switch only after DEBOUNCE_CYCLES unchanged samples.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // The clear compares the sample about to enter the second stage with the
  // one already there, so the window opens on the synchronised edge itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync1_q != sync2_q)    cnt_d = '0;
    else if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST)     stable_d = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/game_select_ctrl.sv
// Decides which game owns the shared VGA/LED/HEX outputs; a selection change
// waits for a frame boundary, then blanks the screen while the new game resets.
module game_select_ctrl
  import console_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLANK_CYCLES    = 1666667,
  parameter int RST_CYCLES      = 16
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  game_select_ctrl_if.slave  bus
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [BW-1:0] RST_LEN    = BW'(RST_CYCLES);

  state_e        state_q, state_d;
  logic          cur_q, cur_d;
  logic          tgt_q, tgt_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic          vs_sync1_q, vs_sync2_q, vs_prev_q;
  logic          frame_edge;
  logic          stable;
  ctrl_out_t     out_q, out_d;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .sw_i     (bus.mode_sw),
    .stable_o (stable)
  );

  assign frame_edge = vs_prev_q & ~vs_sync2_q;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      RUN: begin
        if (stable != cur_q) begin
          tgt_d   = stable;
          state_d = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (stable == cur_q) begin
          state_d = RUN;
        end else if (frame_edge) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
          cur_d       = tgt_q;
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) state_d = RUN;
        else                           blank_cnt_d = blank_cnt_q + 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs decode the next state so they register on the same edge as it.
  always_comb begin
    out_d             = CTRL_OUT_RESET;
    out_d.sel         = cur_d;
    out_d.game_en     = game_onehot(cur_d);
    out_d.game_rst_n  = 2'b11;
    out_d.blank_force = 1'b0;
    out_d.busy        = 1'b0;
    case (state_d)
      WAIT_VS: out_d.busy = 1'b1;
      BLANK: begin
        out_d.game_en     = 2'b00;
        out_d.blank_force = 1'b1;
        out_d.busy        = 1'b1;
        if (blank_cnt_d < RST_LEN) out_d.game_rst_n = ~game_onehot(cur_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RUN;
      cur_q       <= GAME_PONG;
      tgt_q       <= GAME_PONG;
      blank_cnt_q <= '0;
      vs_sync1_q  <= 1'b1;
      vs_sync2_q  <= 1'b1;
      vs_prev_q   <= 1'b1;
      out_q       <= CTRL_OUT_RESET;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      blank_cnt_q <= blank_cnt_d;
      vs_sync1_q  <= bus.vga_vs;
      vs_sync2_q  <= vs_sync1_q;
      vs_prev_q   <= vs_sync2_q;
      out_q       <= out_d;
    end
  end

  assign bus.sel         = out_q.sel;
  assign bus.game_en     = out_q.game_en;
  assign bus.game_rst_n  = out_q.game_rst_n;
  assign bus.blank_force = out_q.blank_force;
  assign bus.busy        = out_q.busy;

endmodule
